// File: rtl/regfile_pipe_pkg.sv
// rtl/regfile_pipe_pkg.sv - shared constants and helpers for the register file
package regfile_pipe_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

   // Smallest n with 2**n >= value; at least 1 so a 2-entry file still has an address bit.
   function automatic int clog2(input int value);
      int n;
      n = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << n) < value) begin
            n = n + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/regfile_pipe_if.sv
// rtl/regfile_pipe_if.sv - write/read bus of the register file
interface regfile_pipe_if
   import regfile_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AW    = clog2(DEFAULT_DEPTH)
) ();

   logic             clear;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             re_a;
   logic [AW-1:0]    raddr_a;
   logic [WIDTH-1:0] rdata_a;
   logic             rvalid_a;
   logic             re_b;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_b;
   logic             rvalid_b;

   modport master (
      output clear, we, waddr, wdata,
      output re_a, raddr_a, re_b, raddr_b,
      input  rdata_a, rvalid_a, rdata_b, rvalid_b
   );

   modport slave (
      input  clear, we, waddr, wdata,
      input  re_a, raddr_a, re_b, raddr_b,
      output rdata_a, rvalid_a, rdata_b, rvalid_b
   );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port with write bypass
module regfile_read_port
   import regfile_pipe_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int AW       = clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [WIDTH-1:0] regs [DEPTH],
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid
);

   logic             is_zero;
   logic             bypass;
   logic [WIDTH-1:0] next_data;

   // Select what the register will hold after this edge: clear wins, then the
   // hardwired zero register, then a same-edge write, then the stored value.
   always_comb begin
      is_zero   = (ZERO_REG != 0) && (raddr == '0);
      bypass    = we && (raddr == waddr) && !is_zero;
      next_data = regs[raddr];
      if (clear || is_zero) begin
         next_data = '0;
      end else if (bypass) begin
         next_data = wdata;
      end
   end

   // Output register: data only moves on a request, valid pulses one cycle per request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) begin
            rdata <= next_data;
         end
      end
   end

endmodule

// File: rtl/regfile_pipe.sv
// rtl/regfile_pipe.sv - flop-based register file with two registered read ports
module regfile_pipe
   import regfile_pipe_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ZERO_REG = 1
) (
   input  logic           clock,
   input  logic           reset_n,
   regfile_pipe_if.slave  bus
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] wen;

   // One-hot write-enable decode; entry 0 never enables when it is the zero register.
   always_comb begin
      wen = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wen[i] = bus.we && (bus.waddr == AW'(i));
      end
      if (ZERO_REG != 0) begin
         wen[0] = 1'b0;
      end
   end

   // Storage flops: reset and clear zero the whole file, clear beats a write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.clear) begin
               regs[i] <= '0;
            end else if (wen[i]) begin
               regs[i] <= bus.wdata;
            end
         end
      end
   end

   regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_port_a (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (bus.clear),
      .re       (bus.re_a),
      .raddr    (bus.raddr_a),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .regs     (regs),
      .rdata    (bus.rdata_a),
      .rvalid   (bus.rvalid_a)
   );

   regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_port_b (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (bus.clear),
      .re       (bus.re_b),
      .raddr    (bus.raddr_b),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .regs     (regs),
      .rdata    (bus.rdata_b),
      .rvalid   (bus.rvalid_b)
   );

endmodule

// File: tb/tb_regfile_pipe.sv
// tb/tb_regfile_pipe.sv - scoreboard bench for regfile_pipe
module tb_regfile_pipe;

   logic clock;
   logic reset_n;

   int checks;
   int failures;

   logic [31:0] model [32];
   logic [31:0] qa [$];
   logic [31:0] qb [$];
   logic [31:0] last_a;
   logic [31:0] last_b;

   regfile_pipe_if #(.WIDTH(32), .AW(5)) bus ();

   regfile_pipe #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Value a read of addr returns given this edge's clear/write inputs.
   function automatic logic [31:0] model_read(input logic c, input logic w, input logic [4:0] wa,
                                             input logic [31:0] wd, input logic [4:0] addr);
      if (c) return 32'h0;
      if (addr == 5'd0) return 32'h0;
      if (w && wa == addr) return wd;
      return model[addr];
   endfunction

   task automatic cycle(input logic c, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ra_en, input logic [4:0] ra,
                        input logic rb_en, input logic [4:0] rb);
      logic [31:0] ea;
      logic [31:0] eb;
      bus.clear   = c;
      bus.we      = w;
      bus.waddr   = wa;
      bus.wdata   = wd;
      bus.re_a    = ra_en;
      bus.raddr_a = ra;
      bus.re_b    = rb_en;
      bus.raddr_b = rb;
      ea = model_read(c, w, wa, wd, ra);
      eb = model_read(c, w, wa, wd, rb);
      @(posedge clock);
      if (ra_en) qa.push_back(ea);
      if (rb_en) qb.push_back(eb);
      if (c) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (w && wa != 5'd0) begin
         model[wa] = wd;
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.clear = 1'b0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
      bus.re_a = 1'b0; bus.raddr_a = '0; bus.re_b = 1'b0; bus.raddr_b = '0;
   endtask

   task automatic flush_model();
      qa.delete();
      qb.delete();
      last_a = 32'h0;
      last_b = 32'h0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Called between edges: assert reset, check outputs drop at once, release later.
   task automatic async_reset();
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_rdata_a", bus.rdata_a, 32'h0);
      chk("rst_rdata_b", bus.rdata_b, 32'h0);
      chk("rst_rvalid_a", {31'h0, bus.rvalid_a}, 32'h0);
      chk("rst_rvalid_b", {31'h0, bus.rvalid_b}, 32'h0);
      flush_model();
      idle_inputs();
      @(posedge clock);
      @(posedge clock);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic expect_now(input string name, input logic [31:0] act, input logic [31:0] exp);
      @(negedge clock);
      #1;
      chk(name, act, exp);
   endtask

   // Monitor: pops the expected response whenever a port shows valid data.
   always @(negedge clock) begin
      if (reset_n) begin
         chk("rvalid_a", {31'h0, bus.rvalid_a}, {31'h0, qa.size() != 0});
         if (qa.size() != 0) begin
            last_a = qa.pop_front();
            chk("rdata_a", bus.rdata_a, last_a);
         end else begin
            chk("hold_a", bus.rdata_a, last_a);
         end
         chk("rvalid_b", {31'h0, bus.rvalid_b}, {31'h0, qb.size() != 0});
         if (qb.size() != 0) begin
            last_b = qb.pop_front();
            chk("rdata_b", bus.rdata_b, last_b);
         end else begin
            chk("hold_b", bus.rdata_b, last_b);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  wa;
      logic [4:0]  ra;
      logic [4:0]  rb;
      checks   = 0;
      failures = 0;
      flush_model();
      idle_inputs();
      reset_n = 1'b0;
      #1;
      chk("init_rdata_a", bus.rdata_a, 32'h0);
      chk("init_rvalid_a", {31'h0, bus.rvalid_a}, 32'h0);
      chk("init_rdata_b", bus.rdata_b, 32'h0);
      chk("init_rvalid_b", {31'h0, bus.rvalid_b}, 32'h0);
      @(posedge clock);
      @(posedge clock);
      #2;
      reset_n = 1'b1;

      // Read right after reset returns zero with valid.
      cycle(0, 0, 0, 0, 1, 5'd5, 0, 0);
      expect_now("reset_read_5", bus.rdata_a, 32'h0);

      // Write then read on the following edge.
      cycle(0, 1, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 5'd7, 0, 0);
      expect_now("write_read_7", bus.rdata_a, 32'hDEADBEEF);

      // Same-edge bypass on port B.
      cycle(0, 1, 5'd3, 32'h12345678, 0, 0, 1, 5'd3);
      expect_now("bypass_b_3", bus.rdata_b, 32'h12345678);

      // Zero register ignores writes, including a same-edge read on both ports.
      cycle(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
      expect_now("zero_bypass_a", bus.rdata_a, 32'h0);
      chk("zero_bypass_b", bus.rdata_b, 32'h0);
      cycle(0, 0, 0, 0, 1, 5'd0, 1, 5'd0);
      expect_now("zero_read_a", bus.rdata_a, 32'h0);
      chk("zero_read_b", bus.rdata_b, 32'h0);

      // Both ports same address, same cycle.
      cycle(0, 0, 0, 0, 1, 5'd7, 1, 5'd7);
      expect_now("same_addr_a", bus.rdata_a, 32'hDEADBEEF);
      chk("same_addr_b", bus.rdata_b, 32'hDEADBEEF);

      // Clear beats a simultaneous write; same-edge read returns zero.
      cycle(0, 1, 5'd9, 32'h11112222, 0, 0, 0, 0);
      cycle(1, 1, 5'd9, 32'hA5A5A5A5, 1, 5'd9, 0, 0);
      expect_now("clear_same_read", bus.rdata_a, 32'h0);
      cycle(0, 0, 0, 0, 1, 5'd9, 1, 5'd7);
      expect_now("clear_read_9", bus.rdata_a, 32'h0);
      chk("clear_read_7", bus.rdata_b, 32'h0);

      // Async reset mid-read discards the pending read and the stored value.
      cycle(0, 1, 5'd4, 32'hCAFEF00D, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 5'd4, 1, 5'd4);
      async_reset();
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      expect_now("post_rst_rvalid_a", {31'h0, bus.rvalid_a}, 32'h0);
      cycle(0, 0, 0, 0, 1, 5'd4, 0, 0);
      expect_now("post_rst_read_4", bus.rdata_a, 32'h0);

      // First write allowed on the first edge after release.
      async_reset();
      cycle(0, 1, 5'd12, 32'h0BADC0DE, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 5'd12);
      expect_now("first_write_12", bus.rdata_b, 32'h0BADC0DE);

      // Randomised traffic with address collisions favoured.
      for (int n = 0; n < 400; n++) begin
         wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         cycle($urandom_range(0, 24) == 0, $urandom_range(0, 1) != 0, wa, $urandom,
               $urandom_range(0, 2) != 0, ra, $urandom_range(0, 2) != 0, rb);
      end

      idle_inputs();
      @(posedge clock);
      @(negedge clock);
      #1;
      chk("drain_a", qa.size(), 32'h0);
      chk("drain_b", qb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_pipe.md
REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 Parameter WIDTH, default 32: bits per register.
REQ-002 Parameter DEPTH, default 32: number of registers; power of two, >= 2.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 Derived constant AW = clog2(DEPTH) SHALL size all address ports.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous clear of all registers.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 re_a / re_b  input  1  read request, ports A / B.
REQ-012 raddr_a / raddr_b  input  AW  read address, ports A / B.
REQ-013 rdata_a / rdata_b  output  WIDTH  registered read data, ports A / B.
REQ-014 rvalid_a / rvalid_b  output  1  high for one cycle when rdata_x is newly valid.

Function
REQ-015 The write SHALL commit on the rising edge where we=1, reset_n=1 and clear=0.
REQ-016 Each read SHALL have 1-cycle latency: a request at edge N drives rdata_x and rvalid_x=1 from edge N until edge N+1.
REQ-017 rvalid_x SHALL be 0 in any cycle following an edge with re_x=0.
REQ-018 rdata_x SHALL hold its last value while re_x=0.
REQ-019 Same-cycle bypass: if re_x=1, we=1 and raddr_x==waddr, rdata_x SHALL return wdata, not the old contents.
REQ-020 With ZERO_REG=1, writes to address 0 SHALL be dropped, reads of address 0 SHALL return 0, and bypass SHALL NOT apply to address 0.
REQ-021 Ports A and B SHALL be independent; both may read the same address in the same cycle with identical results.
REQ-022 clear=1 SHALL zero every register at the edge, take priority over a simultaneous write, and make any same-cycle read return 0 with rvalid_x=1.
REQ-023 Unused address bits are not applicable: DEPTH is a power of two, so every address is valid.

Reset
REQ-024 While reset_n=0, all registers, rdata_a, rdata_b, rvalid_a and rvalid_b SHALL be 0 immediately, independent of clock.
REQ-025 Reset asserted mid-read SHALL discard the pending read; rvalid_x SHALL be 0 on the first edge after release unless a new request is made.
REQ-026 Deassertion SHALL take effect on clock edges only; the first write may occur on the first edge after release.

Structure
REQ-027 A shared package SHALL hold the default WIDTH and DEPTH constants and the clog2 helper.
REQ-028 A single sub-module, regfile_read_port (address mux, bypass compare, output register, valid flag), SHALL be instantiated twice.
REQ-029 Storage SHALL be a flop array with per-register write-enable decode, not inferred RAM, so that asynchronous reset and clear apply.

Verification
REQ-030 Reset then read: release reset_n, re_a=1 with raddr_a=5 -> next cycle rdata_a=0, rvalid_a=1.
REQ-031 Write/read: write 0xDEADBEEF to reg 7, read A at reg 7 on the following edge -> rdata_a=0xDEADBEEF one cycle later.
REQ-032 Bypass: on the same edge, we=1, waddr=3, wdata=0x12345678 and re_b=1, raddr_b=3 -> rdata_b=0x12345678 on the next cycle.
REQ-033 Zero register: write 0xFFFFFFFF to reg 0, then read reg 0 on both ports, including a same-cycle read -> rdata=0 on both ports.
REQ-034 Clear vs write: clear=1 with we=1, waddr=9, wdata=0xA5A5A5A5 -> a later read of reg 9 returns 0.
REQ-035 Async reset mid-op: after reg 4 is loaded, drop reset_n between clock edges -> all outputs 0 at once, and a later read of reg 4 returns 0.
